// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Bundles the requester byte streams and the TX FIFO write port
//            shared by uart_tx_arbiter and the logic around it.
// Ports    : req_valid/req_data/req_last/req_ready - NUM_REQ byte streams
//            tx_full/tx_we/tx_data                 - TX FIFO write side
//            grant_id/busy                         - arbiter status
// Modports : slave  - the arbiter itself
//            master - producers, TX FIFO model and observers
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_full;
    logic                 tx_we;
    logic [7:0]           tx_data;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  tx_full,
        output req_ready,
        output tx_we,
        output tx_data,
        output grant_id,
        output busy
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output tx_full,
        input  req_ready,
        input  tx_we,
        input  tx_data,
        input  grant_id,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART TX FIFO write port between
//            NUM_REQ byte-stream requesters. A grant lasts for one burst,
//            ended by req_last or by MAX_BURST accepted bytes.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high reset
//            bus  - uart_tx_arbiter_if.slave (requester streams, TX FIFO
//                   write port, grant_id, busy)
// Params   : NUM_REQ   (2..8) number of requesters
//            MAX_BURST (>=1)  bytes per grant before forced rotation
// Macro    : UART_ARB_TAG_EN - when defined, each grant first writes a
//            header byte {4'hA, grant_id} before the payload.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    // beat_cnt value of the last byte a grant may take before rotating
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1
`ifdef UART_ARB_TAG_EN
        ,
        S_TAG  = 2'd2
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [7:0]         req_byte_w [NUM_REQ];
    logic [GW-1:0]      sel_id_w;
    logic               sel_found_w;
    logic [GW-1:0]      scan_w;
    logic [NUM_REQ-1:0] req_ready_w;
    logic               tx_we_w;
    logic [7:0]         tx_data_w;
    logic               accept_w;
    logic               end_burst_w;

    // Increment modulo NUM_REQ; NUM_REQ need not be a power of two.
    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
        if (v == GW'(NUM_REQ - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // Split the flat data bus into one byte per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_byte_w[gi] = bus.req_data[8*gi +: 8];
    end

    // Round-robin scan: first valid index at or above rr_ptr, wrapping.
    always_comb begin
        sel_found_w = 1'b0;
        sel_id_w    = '0;
        scan_w      = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found_w && bus.req_valid[scan_w]) begin
                sel_found_w = 1'b1;
                sel_id_w    = scan_w;
            end
            scan_w = wrap_inc(scan_w);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        req_ready_w = '0;
        tx_we_w     = 1'b0;
        tx_data_w   = 8'h00;
        accept_w    = 1'b0;
        end_burst_w = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Requests are only looked at here; a late riser waits for
                // the next arbitration round.
                if (sel_found_w) begin
                    grant_id_d = sel_id_w;
                    beat_cnt_d = '0;
`ifdef UART_ARB_TAG_EN
                    state_d    = S_TAG;
`else
                    state_d    = S_XFER;
`endif
                end
            end

`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                // Header byte identifies the grantee to the receiving end.
                if (!bus.tx_full) begin
                    tx_we_w   = 1'b1;
                    tx_data_w = {4'hA, 4'(grant_id_q)};
                    state_d   = S_XFER;
                end
            end
`endif

            S_XFER: begin
                // Ready is offered whenever the FIFO has room, independent of
                // valid, so a producer may present data in the same cycle.
                req_ready_w[grant_id_q] = ~bus.tx_full;
                accept_w = bus.req_valid[grant_id_q] & ~bus.tx_full;
                if (accept_w) begin
                    tx_we_w     = 1'b1;
                    tx_data_w   = req_byte_w[grant_id_q];
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    end_burst_w = bus.req_last[grant_id_q] ||
                                  (beat_cnt_q == LAST_BEAT);
                    if (end_burst_w) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = wrap_inc(grant_id_q);
                    end
                end
                // A grantee that drops valid keeps the grant; no timeout.
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (combinational, no register stage in the data path)
    // ------------------------------------------------------------------------
    assign bus.req_ready = req_ready_w;
    assign bus.tx_we     = tx_we_w;
    assign bus.tx_data   = tx_data_w;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter. Producers are
//            per-requester byte queues; every TX FIFO write is logged and
//            compared against hand-built expected streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 16;
`ifdef UART_ARB_TAG_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ------------------------------------------------------------------------
    // Producer side
    // ------------------------------------------------------------------------
    logic [7:0]           qd [NUM_REQ][$];
    logic                 ql [NUM_REQ][$];
    logic [NUM_REQ-1:0]   drv_valid = '0;
    logic [NUM_REQ*8-1:0] drv_data  = '0;
    logic [NUM_REQ-1:0]   drv_last  = '0;
    logic [NUM_REQ-1:0]   en        = '1;
    logic [NUM_REQ-1:0]   pop       = '0;
    logic                 full      = 1'b0;

    assign bus.req_valid = drv_valid & en;
    assign bus.req_data  = drv_data;
    assign bus.req_last  = drv_last;
    assign bus.tx_full   = full;

    // ------------------------------------------------------------------------
    // Write log, sampled on the falling edge
    // ------------------------------------------------------------------------
    int         cyc = 0;
    logic [7:0] log_b [$];
    int         log_g [$];
    int         log_c [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++)
            pop[i] = bus.req_valid[i] & bus.req_ready[i];
        if (bus.tx_we === 1'b1) begin
            log_b.push_back(bus.tx_data);
            log_g.push_back(int'(bus.grant_id));
            log_c.push_back(cyc);
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    int         n_cmp = 0;
    int         n_err = 0;
    int         base  = 0;
    logic [7:0] eb [$];
    int         eg [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_valid[i]        = (qd[i].size() > 0);
            drv_data[8*i +: 8]  = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
            drv_last[i]         = (qd[i].size() > 0) ? ql[i][0] : 1'b0;
        end
    endtask

    // Advance one cycle: apply last cycle's handshakes, then re-drive.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pop[i] && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        end
        refresh();
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        qd[r].push_back(b);
        ql[r].push_back(l);
    endtask

    task automatic exp_hdr(input int g);
        if (HDR != 0) begin
            eb.push_back(8'hA0 | 8'(g));
            eg.push_back(g);
        end
    endtask

    task automatic exp_byte(input int g, input logic [7:0] b);
        eb.push_back(b);
        eg.push_back(g);
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && (log_b.size() - base) < n; k++) tick();
        chk({tag, "_timeout"}, 32'((log_b.size() - base) >= n), 32'd1);
    endtask

    task automatic check_log(input string tag);
        int got;
        got = log_b.size() - base;
        chk({tag, "_count"}, 32'(got), 32'(eb.size()));
        for (int k = 0; k < eb.size() && k < got; k++) begin
            chk($sformatf("%s_byte%0d", tag, k), 32'(log_b[base+k]), 32'(eb[k]));
            chk($sformatf("%s_gid%0d", tag, k), 32'(log_g[base+k]), 32'(eg[k]));
        end
        eb.delete();
        eg.delete();
        base = log_b.size();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        full = 1'b0;
        en   = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
        refresh();
        tick();
        tick();
        rst  = 1'b0;
        base = log_b.size();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        refresh();
        tick();
        tick();
        // Reset state
        chk("rst_tx_we", 32'(bus.tx_we), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_gid", 32'(bus.grant_id), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single requester: req 2 sends 11,22,33
        do_reset();
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        refresh();
        exp_hdr(2);
        exp_byte(2, 8'h11);
        exp_byte(2, 8'h22);
        exp_byte(2, 8'h33);
        wait_log(3 + HDR, 50, "single");
        chk("single_gap1", 32'(log_c[base+HDR+1] - log_c[base+HDR]), 32'd1);
        chk("single_gap2", 32'(log_c[base+HDR+2] - log_c[base+HDR+1]), 32'd1);
        check_log("single");
        tick();
        tick();
        chk("single_gid_hold", 32'(bus.grant_id), 32'd2);
        chk("single_busy_end", 32'(bus.busy), 32'd0);
        // rr_ptr is now 3: req 3 must win over req 1, then req 1.
        push(1, 8'h51, 1'b1);
        push(3, 8'h53, 1'b1);
        refresh();
        exp_hdr(3);
        exp_byte(3, 8'h53);
        exp_hdr(1);
        exp_byte(1, 8'h51);
        wait_log(2 + 2 * HDR, 50, "rrptr");
        check_log("rrptr");

        // Round-robin: all valid, one-byte bursts
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            for (int r = 0; r < 2; r++)
                push(i, 8'(8'h80 + 16 * i + r), 1'b1);
        refresh();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) begin
                exp_hdr(i);
                exp_byte(i, 8'(8'h80 + 16 * i + r));
            end
        wait_log(8 * (1 + HDR), 200, "rr");
        for (int j = 0; j < 7; j++)
            chk($sformatf("rr_period%0d", j),
                32'(log_c[base+(j+1)*(1+HDR)+HDR] - log_c[base+j*(1+HDR)+HDR]),
                32'(2 + HDR));
        check_log("rr");

        // Burst cap: req 0 streams 40 bytes without last, req 1 one byte
        do_reset();
        for (int k = 0; k < 40; k++) push(0, 8'(k), 1'b0);
        push(1, 8'hF1, 1'b1);
        refresh();
        exp_hdr(0);
        for (int k = 0; k < 16; k++) exp_byte(0, 8'(k));
        exp_hdr(1);
        exp_byte(1, 8'hF1);
        exp_hdr(0);
        for (int k = 16; k < 32; k++) exp_byte(0, 8'(k));
        exp_hdr(0);
        for (int k = 32; k < 40; k++) exp_byte(0, 8'(k));
        wait_log(41 + 4 * HDR, 400, "cap");
        check_log("cap");
        tick();
        tick();
        chk("cap_hold_busy", 32'(bus.busy), 32'd1);
        chk("cap_hold_gid", 32'(bus.grant_id), 32'd0);

        // Backpressure: tx_full for 5 cycles mid-burst
        do_reset();
        for (int k = 0; k < 8; k++) push(0, 8'(8'hA0 + k), (k == 7));
        refresh();
        wait_log(3 + HDR, 50, "bp_pre");
        full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) tick();
            #1;
            chk($sformatf("bp_we%0d", c), 32'(bus.tx_we), 32'd0);
            chk($sformatf("bp_ready%0d", c), 32'(bus.req_ready), 32'd0);
        end
        tick();
        full = 1'b0;
        #1;
        chk("bp_resume_we", 32'(bus.tx_we), 32'd1);
        chk("bp_resume_data", 32'(bus.tx_data), 32'hA3);
        chk("bp_resume_ready", 32'(bus.req_ready), 32'b0001);
        exp_hdr(0);
        for (int k = 0; k < 8; k++) exp_byte(0, 8'(8'hA0 + k));
        wait_log(8 + HDR, 50, "bp");
        check_log("bp");

        // Valid gap: grantee drops valid for 4 cycles, req 1 waiting
        do_reset();
        for (int k = 0; k < 6; k++) push(0, 8'(8'hB0 + k), (k == 5));
        push(1, 8'hC1, 1'b1);
        refresh();
        wait_log(2 + HDR, 50, "gap_pre");
        en[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) tick();
            #1;
            chk($sformatf("gap_we%0d", c), 32'(bus.tx_we), 32'd0);
            chk($sformatf("gap_busy%0d", c), 32'(bus.busy), 32'd1);
            chk($sformatf("gap_gid%0d", c), 32'(bus.grant_id), 32'd0);
        end
        tick();
        en[0] = 1'b1;
        #1;
        chk("gap_resume_we", 32'(bus.tx_we), 32'd1);
        chk("gap_resume_data", 32'(bus.tx_data), 32'hB2);
        exp_hdr(0);
        for (int k = 0; k < 6; k++) exp_byte(0, 8'(8'hB0 + k));
        exp_hdr(1);
        exp_byte(1, 8'hC1);
        wait_log(7 + 2 * HDR, 80, "gap");
        check_log("gap");

        // Reset asserted mid-burst
        do_reset();
        for (int k = 0; k < 10; k++) push(0, 8'(8'hD0 + k), (k == 9));
        refresh();
        wait_log(3 + HDR, 50, "mrst_pre");
        rst = 1'b1;
        #1;
        chk("mrst_we", 32'(bus.tx_we), 32'd0);
        chk("mrst_data", 32'(bus.tx_data), 32'h00);
        chk("mrst_ready", 32'(bus.req_ready), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_gid", 32'(bus.grant_id), 32'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
        refresh();
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("mrst_after_busy", 32'(bus.busy), 32'd0);
        exp_hdr(0);
        for (int k = 0; k < 3; k++) exp_byte(0, 8'(8'hD0 + k));
        check_log("mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
